core_scheduler: RTL and testbench
=================================

CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 SHALL have parameter THREADS, default 4, meaning the number of thread lanes sequenced by this core.
REQ-002 SHALL have parameter PC_BITS, default 8, meaning the program counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port start, input, 1 bit: level that launches block execution from IDLE.
REQ-006 SHALL have port thread_enable, input, THREADS bits: active-thread mask, bit i = thread i.
REQ-007 SHALL have port fetch_req, output, 1 bit: instruction fetch request to the fetcher.
REQ-008 SHALL have port fetch_done, input, 1 bit: fetcher holds the valid instruction.
REQ-009 SHALL have port decoded_mem_read_enable, input, 1 bit, from the decoder.
REQ-010 SHALL have port decoded_mem_write_enable, input, 1 bit, from the decoder.
REQ-011 SHALL have port decoded_ret, input, 1 bit, from the decoder.
REQ-012 SHALL have port lsu_state, input, 2*THREADS bits: per-thread LSU state (00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE).
REQ-013 SHALL have port next_pc, input, PC_BITS*THREADS bits: per-thread next PC from the PC units.
REQ-014 SHALL have port core_state, output, 3 bits: current state, fed to the decoder, ALUs, LSUs and PC units.
REQ-015 SHALL have port current_pc, output, PC_BITS bits: PC of the instruction being executed.
REQ-016 SHALL have port done, output, 1 bit: the block has finished.
REQ-017 SHALL have port error, output, 1 bit: divergence detected (see Configuration).

Function
REQ-018 SHALL encode states as IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111; core_state SHALL be the registered state.
REQ-019 IDLE: when start=1, SHALL go to FETCH with current_pc held at 0; start SHALL be ignored in every state other than IDLE.
REQ-020 FETCH: fetch_req SHALL be 1 in this state only, and the block SHALL remain in FETCH until fetch_done=1, then go to DECODE.
REQ-021 DECODE and REQUEST SHALL each last exactly one cycle, followed by REQUEST and WAIT respectively.
REQ-022 WAIT: if decoded_mem_read_enable=0 and decoded_mem_write_enable=0, SHALL exit to EXECUTE after one cycle.
REQ-023 WAIT: otherwise, SHALL stay while any enabled thread has lsu_state 01 or 10, and exit to EXECUTE the cycle after none does.
REQ-024 WAIT: LSU states of threads disabled in thread_enable SHALL be ignored.
REQ-025 EXECUTE SHALL last one cycle, then go to UPDATE.
REQ-026 UPDATE with decoded_ret=1: SHALL go to DONE, set done=1 and leave current_pc unchanged.
REQ-027 UPDATE with decoded_ret=0: SHALL load current_pc from next_pc of the lowest-index enabled thread (thread 0 if thread_enable=0), then go to FETCH.
REQ-028 The block SHALL NOT increment the PC; PC wrap-around is owned by the PC units and SHALL pass through unmodified.
REQ-029 DONE SHALL hold, with done=1, until reset.
REQ-030 Minimum instruction latency (fetch_done already 1, no memory op) SHALL be 6 cycles FETCH to FETCH.

Reset
REQ-031 Reset assertion SHALL immediately, without waiting for clk, force core_state=IDLE, current_pc=0, done=0, error=0 and fetch_req=0, including mid-instruction or mid-WAIT.
REQ-032 The first state change after reset deassertion SHALL occur on a rising clk edge with start=1.

Configuration
REQ-033 With macro SCHED_DIVERGENCE_CHECK_EN defined, in UPDATE with decoded_ret=0, if any enabled thread's next_pc differs from the selected one, the block SHALL set error=1 (sticky until reset), set done=1 and go to DONE.
REQ-034 With SCHED_DIVERGENCE_CHECK_EN undefined, error SHALL be tied to 0 and no comparison logic SHALL exist.

Verification
REQ-035 Reset, start=1, fetch_done=1, ADD (no memory op, ret=0), next_pc=5 for all threads -> core_state sequence 001,010,011,100,101,110,001; current_pc=5 after UPDATE.
REQ-036 LDR with thread_enable=0011; lsu_state for threads 0/1 = 10 for 3 cycles, then 11; thread 2 held at 10 -> WAIT exits one cycle after threads 0/1 reach 11; thread 2 is ignored.
REQ-037 RET instruction -> DONE, done=1, current_pc unchanged; a later start toggle causes no state change.
REQ-038 fetch_done held 0 for 10 cycles -> stays in FETCH with fetch_req=1; fetch_done=1 -> DECODE next cycle.
REQ-039 Reset driven to 0 during WAIT, between clk edges -> core_state=000, current_pc=0 and done=0 immediately.
REQ-040 With SCHED_DIVERGENCE_CHECK_EN: next_pc = {7,7,9,7}, all threads enabled -> error=1, done=1, DONE; without it: current_pc=7, FETCH, error=0.

Source files
------------

// File: rtl/core_scheduler.sv
// ============================================================================
// core_scheduler
// ----------------------------------------------------------------------------
// Per-core instruction sequencer. It walks every instruction through
// FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE. It holds the core
// in FETCH until the fetcher has the instruction, and in WAIT until every
// enabled thread's LSU has finished. At UPDATE it either retires the block
// (RET) or takes the PC of the lowest-index enabled thread.
//
// Optional feature (compile-time macro):
//   SCHED_DIVERGENCE_CHECK_EN - when defined, UPDATE compares the next_pc of
//                               every enabled thread. A mismatch sets a sticky
//                               error flag and retires the block. When it is
//                               not defined, error is tied to 0.
//
// Parameters:
//   THREADS  - number of thread lanes sequenced by this core
//   PC_BITS  - program counter width
//
// Ports:
//   clk                      in   single clock, rising edge
//   reset                    in   asynchronous reset, active low
//   start                    in   launches block execution (sampled in IDLE only)
//   thread_enable[THREADS]   in   active-thread mask, bit i = thread i
//   fetch_req                out  instruction fetch request (FETCH state only)
//   fetch_done               in   fetcher holds a valid instruction
//   decoded_mem_read_enable  in   current instruction reads memory
//   decoded_mem_write_enable in   current instruction writes memory
//   decoded_ret              in   current instruction is RET
//   lsu_state[2*THREADS]     in   per-thread LSU state (00 idle, 01 req, 10 wait, 11 done)
//   next_pc[PC_BITS*THREADS] in   per-thread next PC from the PC units
//   core_state[3]            out  registered sequencer state
//   current_pc[PC_BITS]      out  PC of the instruction being executed
//   done                     out  block finished (held until reset)
//   error                    out  thread divergence detected (sticky)
// ============================================================================
module core_scheduler #(
    parameter int THREADS = 4,
    parameter int PC_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [THREADS-1:0]         thread_enable,
    output logic                       fetch_req,
    input  logic                       fetch_done,
    input  logic                       decoded_mem_read_enable,
    input  logic                       decoded_mem_write_enable,
    input  logic                       decoded_ret,
    input  logic [2*THREADS-1:0]       lsu_state,
    input  logic [PC_BITS*THREADS-1:0] next_pc,
    output logic [2:0]                 core_state,
    output logic [PC_BITS-1:0]         current_pc,
    output logic                       done,
    output logic                       error
);

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_FETCH   = 3'b001;
    localparam logic [2:0] S_DECODE  = 3'b010;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;
    localparam logic [2:0] S_DONE    = 3'b111;

    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;

    logic [2:0]         state_reg, state_next;
    logic [PC_BITS-1:0] pc_reg, pc_next;
    logic               done_reg, done_next;

    // Per-thread views of the packed input buses.
    logic [PC_BITS-1:0] thread_pc [THREADS];
    logic [THREADS-1:0] lsu_busy;

    genvar gi;
    generate
        for (gi = 0; gi < THREADS; gi++) begin : g_thread
            assign thread_pc[gi] = next_pc[gi*PC_BITS +: PC_BITS];
            // A disabled thread never holds the core in WAIT, whatever its LSU reports.
            assign lsu_busy[gi]  = thread_enable[gi] &&
                                   ((lsu_state[2*gi +: 2] == LSU_REQUESTING) ||
                                    (lsu_state[2*gi +: 2] == LSU_WAITING));
        end
    endgenerate

    // PC of the lowest-index enabled thread. The loop scans downward, so the
    // last hit is the lowest index. With an empty mask the default is thread 0.
    logic [PC_BITS-1:0] sel_pc;
    always_comb begin
        sel_pc = thread_pc[0];
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (thread_enable[i]) begin
                sel_pc = thread_pc[i];
            end
        end
    end

    logic mem_op;
    assign mem_op = decoded_mem_read_enable || decoded_mem_write_enable;

`ifdef SCHED_DIVERGENCE_CHECK_EN
    logic               error_reg, error_next;
    logic [THREADS-1:0] diverge_bits;
    logic               diverge;

    generate
        for (gi = 0; gi < THREADS; gi++) begin : g_diverge
            assign diverge_bits[gi] = thread_enable[gi] && (thread_pc[gi] != sel_pc);
        end
    endgenerate

    assign diverge = |diverge_bits;
    assign error   = error_reg;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        done_next  = done_reg;
`ifdef SCHED_DIVERGENCE_CHECK_EN
        error_next = error_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = '0;
                end
            end
            S_FETCH: begin
                if (fetch_done) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE:  state_next = S_REQUEST;
            S_REQUEST: state_next = S_WAIT;
            S_WAIT: begin
                // Instructions without a memory op spend exactly one cycle here.
                if (!mem_op || !(|lsu_busy)) begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: state_next = S_UPDATE;
            S_UPDATE: begin
                if (decoded_ret) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    // The PC units own increment and wrap-around; take their value as is.
                    pc_next    = sel_pc;
                    state_next = S_FETCH;
`ifdef SCHED_DIVERGENCE_CHECK_EN
                    if (diverge) begin
                        pc_next    = pc_reg;
                        state_next = S_DONE;
                        done_next  = 1'b1;
                        error_next = 1'b1;
                    end
`endif
                end
            end
            S_DONE:    state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            done_reg  <= 1'b0;
`ifdef SCHED_DIVERGENCE_CHECK_EN
            error_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            done_reg  <= done_next;
`ifdef SCHED_DIVERGENCE_CHECK_EN
            error_reg <= error_next;
`endif
        end
    end

    assign core_state = state_reg;
    assign current_pc = pc_reg;
    assign done       = done_reg;
    // Decoded from the registered state, so it drops as soon as reset asserts.
    assign fetch_req  = (state_reg == S_FETCH);

endmodule

// File: tb/tb_core_scheduler.sv
// ============================================================================
// tb_core_scheduler
// ----------------------------------------------------------------------------
// Scoreboard bench for core_scheduler (THREADS=4, PC_BITS=8).
// The stimulus process pushes the expected output tuples
// {core_state, current_pc, done, error, fetch_req} into exp_q before it
// drives each instruction. The monitor pops one tuple from exp_q each time the
// DUT's outputs change, and compares them. Point checks that cannot be seen
// as an output change are posted to probe_q: stalls, an asynchronous reset
// between clock edges, and latency. The monitor compares those as well, so
// all pass/fail counting happens in the monitor.
// ============================================================================
module tb_core_scheduler;

    localparam int THREADS = 4;
    localparam int PC_BITS = 8;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_FETCH   = 3'b001;
    localparam logic [2:0] S_DECODE  = 3'b010;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;
    localparam logic [2:0] S_DONE    = 3'b111;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       start = 1'b0;
    logic [THREADS-1:0]         thread_enable = '1;
    logic                       fetch_req;
    logic                       fetch_done = 1'b1;
    logic                       decoded_mem_read_enable = 1'b0;
    logic                       decoded_mem_write_enable = 1'b0;
    logic                       decoded_ret = 1'b0;
    logic [2*THREADS-1:0]       lsu_state = '0;
    logic [PC_BITS*THREADS-1:0] next_pc = '0;
    logic [2:0]                 core_state;
    logic [PC_BITS-1:0]         current_pc;
    logic                       done;
    logic                       error;

    core_scheduler #(.THREADS(THREADS), .PC_BITS(PC_BITS)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .thread_enable            (thread_enable),
        .fetch_req                (fetch_req),
        .fetch_done               (fetch_done),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .decoded_ret              (decoded_ret),
        .lsu_state                (lsu_state),
        .next_pc                  (next_pc),
        .core_state               (core_state),
        .current_pc               (current_pc),
        .done                     (done),
        .error                    (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef logic [13:0] tuple_t;   // {state[3], pc[8], done, error, fetch_req}
    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } probe_t;

    tuple_t exp_q[$];
    probe_t probe_q[$];
    event   probe_ev;
    int     n_pass  = 0;
    int     n_total = 0;

    function automatic tuple_t mk(input logic [2:0] st, input logic [7:0] pc,
                                  input logic dn, input logic er);
        return {st, pc, dn, er, (st == S_FETCH)};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        tuple_t cur;
        tuple_t prev;
        tuple_t e;
        probe_t p;
        prev = mk(S_IDLE, 8'h00, 1'b0, 1'b0);
        forever begin
            @(negedge clk or probe_ev);
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                n_total++;
                if (p.act === p.exp) n_pass++;
                else $display("FAIL %s: got 0x%0h, expected 0x%0h", p.name, p.act, p.exp);
            end
            cur = {core_state, current_pc, done, error, fetch_req};
            if (cur !== prev) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change: got st=%b pc=%0h done=%b err=%b freq=%b, expected no change",
                             cur[13:11], cur[10:3], cur[2], cur[1], cur[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (cur === e) begin
                        n_pass++;
                        $display("t=%0t st=%b pc=%0h done=%b err=%b freq=%b ok",
                                 $time, cur[13:11], cur[10:3], cur[2], cur[1], cur[0]);
                    end else begin
                        $display("FAIL transition: got st=%b pc=%0h done=%b err=%b freq=%b, expected st=%b pc=%0h done=%b err=%b freq=%b",
                                 cur[13:11], cur[10:3], cur[2], cur[1], cur[0],
                                 e[13:11], e[10:3], e[2], e[1], e[0]);
                    end
                end
                prev = cur;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic probe(input string name, input logic [31:0] act, input logic [31:0] exp);
        probe_t p;
        p.name = name;
        p.act  = act;
        p.exp  = exp;
        probe_q.push_back(p);
        -> probe_ev;
    endtask

    // The five states between FETCH and the outcome of UPDATE, then that outcome.
    task automatic push_instr(input logic [7:0] pc, input tuple_t final_t);
        exp_q.push_back(mk(S_DECODE,  pc, 1'b0, 1'b0));
        exp_q.push_back(mk(S_REQUEST, pc, 1'b0, 1'b0));
        exp_q.push_back(mk(S_WAIT,    pc, 1'b0, 1'b0));
        exp_q.push_back(mk(S_EXECUTE, pc, 1'b0, 1'b0));
        exp_q.push_back(mk(S_UPDATE,  pc, 1'b0, 1'b0));
        exp_q.push_back(final_t);
    endtask

    task automatic wait_state(input logic [2:0] st, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (core_state == st) return;
        end
        probe({"timeout_", name}, 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        tuple_t div_final;

        // Reset asserted from time 0.
        #1;
        probe("reset_state", {29'd0, core_state}, 32'd0);
        probe("reset_pc",    {24'd0, current_pc}, 32'd0);
        probe("reset_flags", {29'd0, done, error, fetch_req}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        probe("idle_without_start", {29'd0, core_state}, {29'd0, S_IDLE});

        // ADD, next_pc = 5 on all threads, minimal latency.
        thread_enable = 4'b1111;
        next_pc = {8'd5, 8'd5, 8'd5, 8'd5};
        fetch_done = 1'b1;
        exp_q.push_back(mk(S_FETCH, 8'h00, 1'b0, 1'b0));
        push_instr(8'h00, mk(S_FETCH, 8'h05, 1'b0, 1'b0));
        start = 1'b1;
        wait_state(S_FETCH, "add_fetch");
        c0 = cyc;
        start = 1'b0;
        wait_state(S_UPDATE, "add_update");
        fetch_done = 1'b0;
        wait_state(S_FETCH, "add_refetch");
        probe("latency_fetch_to_fetch", cyc - c0, 32'd6);
        probe("pc_after_add", {24'd0, current_pc}, 32'd5);

        // Fetch stall for 10 cycles, then LDR with threads 0/1 enabled.
        decoded_mem_read_enable = 1'b1;
        thread_enable = 4'b0011;
        lsu_state = 8'b00_10_10_10;
        next_pc = {8'h41, 8'h40, 8'h12, 8'h12};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            probe("stall_state", {29'd0, core_state}, {29'd0, S_FETCH});
            probe("stall_fetch_req", {31'd0, fetch_req}, 32'd1);
        end
        push_instr(8'h05, mk(S_FETCH, 8'h12, 1'b0, 1'b0));
        fetch_done = 1'b1;
        @(negedge clk);
        probe("decode_after_fetch_done", {29'd0, core_state}, {29'd0, S_DECODE});
        fetch_done = 1'b0;
        wait_state(S_WAIT, "ldr_wait");
        @(negedge clk);
        probe("ldr_wait_2", {29'd0, core_state}, {29'd0, S_WAIT});
        @(negedge clk);
        probe("ldr_wait_3", {29'd0, core_state}, {29'd0, S_WAIT});
        lsu_state = 8'b00_10_11_11;   // threads 0/1 done, thread 2 still busy but disabled
        @(negedge clk);
        probe("ldr_exit_wait", {29'd0, core_state}, {29'd0, S_EXECUTE});
        wait_state(S_FETCH, "ldr_refetch");
        probe("pc_after_ldr", {24'd0, current_pc}, 32'h12);
        decoded_mem_read_enable = 1'b0;

        // STR with LSUs busy; reset asserted between clock edges during WAIT.
        decoded_mem_write_enable = 1'b1;
        thread_enable = 4'b1111;
        lsu_state = 8'b01_01_01_01;
        exp_q.push_back(mk(S_DECODE,  8'h12, 1'b0, 1'b0));
        exp_q.push_back(mk(S_REQUEST, 8'h12, 1'b0, 1'b0));
        exp_q.push_back(mk(S_WAIT,    8'h12, 1'b0, 1'b0));
        exp_q.push_back(mk(S_IDLE,    8'h00, 1'b0, 1'b0));
        fetch_done = 1'b1;
        wait_state(S_DECODE, "str_decode");
        fetch_done = 1'b0;
        wait_state(S_WAIT, "str_wait");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        probe("async_reset_state", {29'd0, core_state}, 32'd0);
        probe("async_reset_pc",    {24'd0, current_pc}, 32'd0);
        probe("async_reset_flags", {29'd0, done, error, fetch_req}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        decoded_mem_write_enable = 1'b0;
        lsu_state = '0;
        repeat (3) @(negedge clk);
        probe("idle_after_reset", {29'd0, core_state}, {29'd0, S_IDLE});

        // Pass-through: lowest enabled thread is 2 (0xFF), then empty mask -> thread 0 (0x00).
        thread_enable = 4'b0100;
        next_pc = {8'h33, 8'hFF, 8'h33, 8'h33};
        fetch_done = 1'b1;
        exp_q.push_back(mk(S_FETCH, 8'h00, 1'b0, 1'b0));
        push_instr(8'h00, mk(S_FETCH, 8'hFF, 1'b0, 1'b0));
        start = 1'b1;
        wait_state(S_FETCH, "pt_fetch");
        start = 1'b0;
        wait_state(S_UPDATE, "pt_update");
        fetch_done = 1'b0;
        wait_state(S_FETCH, "pt_refetch");
        thread_enable = 4'b0000;
        next_pc = {8'h55, 8'h55, 8'h55, 8'h00};
        push_instr(8'hFF, mk(S_FETCH, 8'h00, 1'b0, 1'b0));
        fetch_done = 1'b1;
        wait_state(S_UPDATE, "wrap_update");
        fetch_done = 1'b0;
        wait_state(S_FETCH, "wrap_refetch");
        probe("pc_after_wrap", {24'd0, current_pc}, 32'h00);

        // RET: DONE with PC unchanged, then start toggles are ignored.
        thread_enable = 4'b1111;
        next_pc = {8'h77, 8'h77, 8'h77, 8'h77};
        decoded_ret = 1'b1;
        push_instr(8'h00, mk(S_DONE, 8'h00, 1'b1, 1'b0));
        fetch_done = 1'b1;
        wait_state(S_DONE, "ret_done");
        fetch_done = 1'b0;
        probe("ret_done_flag", {31'd0, done}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            @(negedge clk);
        end
        start = 1'b0;
        probe("done_holds", {29'd0, core_state}, {29'd0, S_DONE});
        decoded_ret = 1'b0;

        // Divergence: thread 1 disagrees with the selected thread 0.
        exp_q.push_back(mk(S_IDLE, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        probe("reset_from_done", {29'd0, core_state, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        next_pc = {8'd7, 8'd7, 8'd9, 8'd7};
`ifdef SCHED_DIVERGENCE_CHECK_EN
        div_final = mk(S_DONE, 8'h00, 1'b1, 1'b1);
`else
        div_final = mk(S_FETCH, 8'h07, 1'b0, 1'b0);
`endif
        exp_q.push_back(mk(S_FETCH, 8'h00, 1'b0, 1'b0));
        push_instr(8'h00, div_final);
        start = 1'b1;
        wait_state(S_FETCH, "div_fetch");
        start = 1'b0;
        fetch_done = 1'b1;
        wait_state(S_UPDATE, "div_update");
        fetch_done = 1'b0;
        @(negedge clk);
        probe("div_error", {31'd0, error}, {31'd0, div_final[1]});

        // Drain and report.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        probe("exp_queue_drained", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
